// File: rtl/pipe_stall_ctrl.sv
// Pipeline-wide stall/flush sequencer: merges per-stage stall requests, times
// multi-cycle EX operations and holds the flush after an exception.
module pipe_stall_ctrl #(
    parameter int unsigned STALL_W      = 6,
    parameter int unsigned MC_LEN_W     = 6,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_if,
    input  logic                stallreq_id,
    input  logic                ex_mc_start,
    input  logic [MC_LEN_W-1:0] ex_mc_len,
    input  logic                excp_req,
    input  logic [31:0]         excp_vector,
    output logic [STALL_W-1:0]  ctrl_stall,
    output logic                flush,
    output logic [31:0]         flush_pc,
    output logic                mc_busy,
    output logic                mc_done
);

    // Each mask holds its own stage and everything upstream of it, PC included.
    localparam logic [STALL_W-1:0] MASK_EX = STALL_W'(4'b1111);
    localparam logic [STALL_W-1:0] MASK_ID = STALL_W'(3'b111);
    localparam logic [STALL_W-1:0] MASK_IF = STALL_W'(2'b11);
    localparam logic [2:0]         FL_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [MC_LEN_W-1:0] MC_ONE = MC_LEN_W'(1);
    localparam logic [MC_LEN_W-1:0] MC_TWO = MC_LEN_W'(2);

    typedef enum logic [1:0] {StRun, StMcWait, StFlush} state_e;

    state_e              state_q, state_d;
    logic [MC_LEN_W-1:0] mc_cnt_q, mc_cnt_d;
    logic [2:0]          fl_cnt_q, fl_cnt_d;
    logic [31:0]         vec_q, vec_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            mc_cnt_q <= '0;
            fl_cnt_q <= '0;
            vec_q    <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            fl_cnt_q <= fl_cnt_d;
            vec_q    <= vec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mc_cnt_d   = mc_cnt_q;
        fl_cnt_d   = fl_cnt_q;
        vec_d      = vec_q;
        ctrl_stall = '0;
        flush      = 1'b0;
        flush_pc   = '0;
        mc_busy    = (state_q == StMcWait);
        mc_done    = 1'b0;

        if (excp_req) begin
            // Exception wins everywhere and silently cancels any in-flight op.
            flush    = 1'b1;
            flush_pc = excp_vector;
            vec_d    = excp_vector;
            fl_cnt_d = FL_INIT;
            mc_cnt_d = '0;
            state_d  = (FLUSH_CYCLES > 1) ? StFlush : StRun;
        end else begin
            case (state_q)
                StFlush: begin
                    flush    = 1'b1;
                    flush_pc = vec_q;
                    fl_cnt_d = fl_cnt_q - 3'd1;
                    if (fl_cnt_q <= 3'd1) begin
                        fl_cnt_d = '0;
                        state_d  = StRun;
                    end
                end
                StMcWait: begin
                    if (mc_cnt_q <= MC_ONE) begin
                        mc_done  = 1'b1;
                        mc_cnt_d = '0;
                        state_d  = StRun;
                    end else begin
                        ctrl_stall = MASK_EX;
                        mc_cnt_d   = mc_cnt_q - MC_ONE;
                    end
                end
                StRun: begin
                    if (ex_mc_start && (ex_mc_len >= MC_TWO)) begin
                        ctrl_stall = MASK_EX;
                        mc_cnt_d   = ex_mc_len - MC_ONE;
                        state_d    = StMcWait;
                    end else if (stallreq_id) begin
                        ctrl_stall = MASK_ID;
                    end else if (stallreq_if) begin
                        ctrl_stall = MASK_IF;
                    end
                end
                default: state_d = StRun;
            endcase
        end

        // Reset aborts everything in the same cycle, including a pending mc_done.
        if (rst) begin
            ctrl_stall = '0;
            flush      = 1'b0;
            flush_pc   = '0;
            mc_busy    = 1'b0;
            mc_done    = 1'b0;
        end
    end

endmodule
